// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the datapath / memory port.
// master: the controller (samples op and mem_ready, drives every control strobe)
// slave : the datapath side (drives op from the IR and mem_ready from memory)
interface multicycle_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       op;
    logic             mem_ready;
    logic             pcwrite;
    logic             branch;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [1:0]       aluop;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, mem_ready,
        output pcwrite, branch, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, state, instret
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, branch, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, state, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle MIPS datapath (R-type, LW, SW, BEQ, ADDI, J).
// Define MC_ORI_EN to add ORI support through the ORIEX state; otherwise ORI is illegal
// and state 13 behaves like any other undefined code.
module multicycle_controller #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StIexec  = 4'd10,
        StIwb    = 4'd11,
        StJump   = 4'd12,
        StOriex  = 4'd13
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpOri   = 6'b001101;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             mem_rdy;
    logic             retire;

    // Without the handshake every memory access completes in one cycle
    assign mem_rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    // State register and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic; undefined codes recover to FETCH
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_rdy) state_d = StDecode;
            StDecode: begin
                case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StIexec;
                    OpJ:        state_d = StJump;
`ifdef MC_ORI_EN
                    OpOri:      state_d = StOriex;
`endif
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (bus.op == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_rdy) state_d = StMemWb;
            StMemWr:  if (mem_rdy) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StIexec:  state_d = StIwb;
`ifdef MC_ORI_EN
            StOriex:  state_d = StIwb;
`endif
            StMemWb, StAluWb, StBranch, StIwb, StJump: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // Count only completed instructions; illegal-op and IDLE returns to FETCH do not retire
    always_comb begin
        retire = 1'b0;
        if (state_d == StFetch) begin
            case (state_q)
                StMemWb, StMemWr, StAluWb, StBranch, StIwb, StJump: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // Moore outputs; FETCH gates its PC/IR writes with mem_ready
    always_comb begin
        bus.pcwrite    = 1'b0;
        bus.branch     = 1'b0;
        bus.iord       = 1'b0;
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regdst     = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.aluop      = 2'b00;
        bus.illegal_op = 1'b0;
        case (state_q)
            StFetch: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                bus.pcwrite = mem_rdy;
                bus.irwrite = mem_rdy;
            end
            StDecode: begin
                bus.alusrcb    = 2'b11;
                // Only an unsupported opcode sends DECODE straight back to FETCH
                bus.illegal_op = (state_d == StFetch);
            end
            StMemAdr: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            StMemRd: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            StMemWb: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            StMemWr: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            StExec: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            StAluWb: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            StBranch: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.branch  = 1'b1;
            end
            StIexec: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            StIwb:   bus.regwrite = 1'b1;
            StJump: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
`ifdef MC_ORI_EN
            StOriex: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b11;
            end
`endif
            default: ;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.instret = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus pushes the hand-computed state,
// control word and instret expected for each cycle; a monitor pops and compares at negedge.
// A second instance runs with MEM_HANDSHAKE=0 and mem_ready=0, executing J forever.
// Honors MC_ORI_EN for the ORI expectations.
module tb_multicycle_controller;
    localparam int unsigned CW = 4;

    // Control word order:
    // pcwrite branch iord memread memwrite irwrite memtoreg regdst regwrite alusrca
    // alusrcb[1:0] pcsrc[1:0] aluop[1:0] illegal_op
    localparam logic [16:0] C_IDLE   = '0;
    localparam logic [16:0] C_FETCH  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                        1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_FETCHW = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_DECODE = {10'b0, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_DECILL = {10'b0, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] C_MEMADR = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_MEMRD  = {1'b0, 1'b0, 1'b1, 1'b1, 6'b0, 7'b0};
    localparam logic [16:0] C_MEMWB  = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0};
    localparam logic [16:0] C_MEMWR  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b0, 7'b0};
    localparam logic [16:0] C_EXEC   = {9'b0, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [16:0] C_ALUWB  = {7'b0, 1'b1, 1'b1, 1'b0, 7'b0};
    localparam logic [16:0] C_BRANCH = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [16:0] C_IEXEC  = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] C_IWB    = {8'b0, 1'b1, 1'b0, 7'b0};
    localparam logic [16:0] C_JUMP   = {1'b1, 9'b0, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] C_ORIEX  = {9'b0, 1'b1, 2'b10, 2'b00, 2'b11, 1'b0};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_BAD = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] cw;
        logic [3:0]  ret;
    } exp_t;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] pw_iw;
        logic [3:0] ret;
    } exp_nh_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(CW)) bus ();
    multicycle_controller_if #(.CNT_W(CW)) bus_nh ();

    multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multicycle_controller #(.MEM_HANDSHAKE(1'b0), .CNT_W(CW)) dut_nh (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nh)
    );

    logic [16:0] act_cw;
    assign act_cw = {bus.pcwrite, bus.branch, bus.iord, bus.memread, bus.memwrite, bus.irwrite,
                     bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc,
                     bus.aluop, bus.illegal_op};

    exp_t    q[$];
    exp_nh_t q_nh[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    logic [3:0] exp_ret = '0;
    logic [3:0] nh_st   = 4'd0;
    logic [3:0] nh_ret  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what both instances should show during it
    task automatic step(input logic rst_v, input logic [5:0] op_v, input logic rdy_v,
                        input logic [3:0] st, input logic [16:0] cw);
        exp_t    e;
        exp_nh_t en;
        @(posedge clk);
        #1;
        rst_n         = rst_v;
        bus.op        = op_v;
        bus.mem_ready = rdy_v;
        if (!rst_v) begin
            exp_ret = '0;
            nh_st   = 4'd0;
            nh_ret  = '0;
        end
        e.st  = st;
        e.cw  = cw;
        e.ret = exp_ret;
        q.push_back(e);
        en.st    = nh_st;
        en.pw_iw = (nh_st == 4'd1) ? 2'b11 : (nh_st == 4'd12) ? 2'b10 : 2'b00;
        en.ret   = nh_ret;
        q_nh.push_back(en);
        if (rst_v) begin
            case (nh_st)
                4'd0:    nh_st = 4'd1;
                4'd1:    nh_st = 4'd2;
                4'd2:    nh_st = 4'd12;
                default: begin
                    nh_st  = 4'd1;
                    nh_ret = nh_ret + 4'd1;
                end
            endcase
        end
    endtask

    task automatic retire();
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic run_j();
        step(1'b1, OP_J, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_J, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_J, 1'b1, 4'd12, C_JUMP);
        retire();
    endtask

    // Monitor: compare every cycle that has a queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("state", 32'(bus.state), 32'(e.st));
                chk("ctrl", 32'(act_cw), 32'(e.cw));
                chk("instret", 32'(bus.instret), 32'(e.ret));
            end
            if (q_nh.size() > 0) begin
                exp_nh_t en;
                en = q_nh.pop_front();
                chk("nh_state", 32'(bus_nh.state), 32'(en.st));
                chk("nh_pcw_irw", 32'({bus_nh.pcwrite, bus_nh.irwrite}), 32'(en.pw_iw));
                chk("nh_instret", 32'(bus_nh.instret), 32'(en.ret));
            end
        end
    end

    initial begin
        bus.op           = OP_R;
        bus.mem_ready    = 1'b0;
        bus_nh.op        = OP_J;
        bus_nh.mem_ready = 1'b0;

        // Reset held three cycles, then IDLE for one cycle
        repeat (3) step(1'b0, OP_R, 1'b1, 4'd0, C_IDLE);
        step(1'b1, OP_R, 1'b1, 4'd0, C_IDLE);

        // R-type
        step(1'b1, OP_R, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_R, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_R, 1'b1, 4'd7, C_EXEC);
        step(1'b1, OP_R, 1'b1, 4'd8, C_ALUWB);
        retire();

        // LW with one FETCH wait and two MEMRD waits
        step(1'b1, OP_LW, 1'b0, 4'd1, C_FETCHW);
        step(1'b1, OP_LW, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_LW, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_LW, 1'b0, 4'd3, C_MEMADR);
        step(1'b1, OP_LW, 1'b0, 4'd4, C_MEMRD);
        step(1'b1, OP_LW, 1'b0, 4'd4, C_MEMRD);
        step(1'b1, OP_LW, 1'b1, 4'd4, C_MEMRD);
        step(1'b1, OP_LW, 1'b1, 4'd5, C_MEMWB);
        retire();

        // SW, BEQ, J
        step(1'b1, OP_SW, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_SW, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_SW, 1'b1, 4'd3, C_MEMADR);
        step(1'b1, OP_SW, 1'b1, 4'd6, C_MEMWR);
        retire();
        step(1'b1, OP_BEQ, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_BEQ, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_BEQ, 1'b1, 4'd9, C_BRANCH);
        retire();
        run_j();

        // ADDI
        step(1'b1, OP_ADDI, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_ADDI, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_ADDI, 1'b1, 4'd10, C_IEXEC);
        step(1'b1, OP_ADDI, 1'b1, 4'd11, C_IWB);
        retire();

        // Illegal opcode: one-cycle pulse, no retire
        step(1'b1, OP_BAD, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_BAD, 1'b1, 4'd2, C_DECILL);

        // ORI
        step(1'b1, OP_ORI, 1'b1, 4'd1, C_FETCH);
`ifdef MC_ORI_EN
        step(1'b1, OP_ORI, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_ORI, 1'b1, 4'd13, C_ORIEX);
        step(1'b1, OP_ORI, 1'b1, 4'd11, C_IWB);
        retire();
`else
        step(1'b1, OP_ORI, 1'b1, 4'd2, C_DECILL);
`endif

        // Enough jumps to carry the 4-bit counter through 15 -> 0
        for (int i = 0; i < 14; i++) run_j();

        // Reset dropped while MEMWR is waiting
        step(1'b1, OP_SW, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_SW, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_SW, 1'b0, 4'd3, C_MEMADR);
        step(1'b1, OP_SW, 1'b0, 4'd6, C_MEMWR);
        step(1'b1, OP_SW, 1'b0, 4'd6, C_MEMWR);
        step(1'b0, OP_SW, 1'b0, 4'd0, C_IDLE);
        step(1'b1, OP_R, 1'b1, 4'd0, C_IDLE);

        // Recovery: one R-type after reset
        step(1'b1, OP_R, 1'b1, 4'd1, C_FETCH);
        step(1'b1, OP_R, 1'b1, 4'd2, C_DECODE);
        step(1'b1, OP_R, 1'b1, 4'd7, C_EXEC);
        step(1'b1, OP_R, 1'b1, 4'd8, C_ALUWB);
        retire();
        step(1'b1, OP_R, 1'b1, 4'd1, C_FETCH);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("nh_queue_drained", 32'(q_nh.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
